// File: rtl/virtual_ds2431_byte_tx.sv
// rtl/virtual_ds2431_byte_tx.sv - 1-Wire slave byte transmitter answering master read slots LSB first
module virtual_ds2431_byte_tx #(
    parameter int HOLD_CYC    = 1500,
    parameter int RST_DET_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dqIn,
    input  logic [7:0] sentDat,
    input  logic       transTrig,
    output logic       dqPullLow,
    output logic       byteTransDone,
    output logic       busy,
    output logic       busResetDet
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        DRIVE,
        RECOVER,
        DONE
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_DET_CYC - 1);

    state_t      state;
    state_t      stateNext;
    logic        dqMeta;
    logic        dqSync;
    logic        dqDly;
    logic        fallEdge;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic [2:0]  bitCnt;
    logic [2:0]  bitCntNext;
    logic [15:0] holdCnt;
    logic [15:0] holdCntNext;
    logic [15:0] lowCnt;
    logic [15:0] lowCntNext;
    logic        pullNext;
    logic        rstDetNext;
    logic        inByte;

    // Synchronise the bus level and register the falling-edge strobe; idle bus reads high.
    always_ff @(posedge clk) begin
        if (rst) begin
            dqMeta   <= 1'b1;
            dqSync   <= 1'b1;
            dqDly    <= 1'b1;
            fallEdge <= 1'b0;
        end else begin
            dqMeta   <= dqIn;
            dqSync   <= dqMeta;
            dqDly    <= dqSync;
            fallEdge <= dqDly & ~dqSync;
        end
    end

    // State and datapath registers; reset releases DQ on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shiftReg    <= 8'd0;
            bitCnt      <= 3'd0;
            holdCnt     <= 16'd0;
            lowCnt      <= 16'd0;
            dqPullLow   <= 1'b0;
            busResetDet <= 1'b0;
        end else begin
            state       <= stateNext;
            shiftReg    <= shiftNext;
            bitCnt      <= bitCntNext;
            holdCnt     <= holdCntNext;
            lowCnt      <= lowCntNext;
            dqPullLow   <= pullNext;
            busResetDet <= rstDetNext;
        end
    end

    assign inByte = (state == WAIT_SLOT) || (state == DRIVE) || (state == RECOVER);

    // Slot sequencing, saturating low-time counter and master-reset abort (abort wins).
    always_comb begin
        stateNext   = state;
        shiftNext   = shiftReg;
        bitCntNext  = bitCnt;
        holdCntNext = holdCnt;
        pullNext    = dqPullLow;
        rstDetNext  = 1'b0;
        lowCntNext  = 16'd0;

        if (inByte && !dqSync) begin
            lowCntNext = (lowCnt == 16'hFFFF) ? lowCnt : lowCnt + 16'd1;
        end

        case (state)
            IDLE: begin
                pullNext = 1'b0;
                if (transTrig) begin
                    shiftNext  = sentDat;
                    bitCntNext = 3'd0;
                    stateNext  = WAIT_SLOT;
                end
            end
            WAIT_SLOT: begin
                if (fallEdge) begin
                    if (!shiftReg[0]) begin
                        pullNext    = 1'b1;
                        holdCntNext = HOLD_LOAD;
                        stateNext   = DRIVE;
                    end else begin
                        stateNext = RECOVER;
                    end
                end
            end
            DRIVE: begin
                if (holdCnt == 16'd0) begin
                    pullNext  = 1'b0;
                    stateNext = RECOVER;
                end else begin
                    holdCntNext = holdCnt - 16'd1;
                end
            end
            RECOVER: begin
                if (dqSync) begin
                    shiftNext  = {1'b0, shiftReg[7:1]};
                    bitCntNext = bitCnt + 3'd1;
                    stateNext  = (bitCnt == 3'd7) ? DONE : WAIT_SLOT;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                pullNext  = 1'b0;
            end
        endcase

        if (inByte && !dqSync && (lowCnt >= RST_LAST)) begin
            stateNext  = IDLE;
            pullNext   = 1'b0;
            rstDetNext = 1'b1;
            lowCntNext = 16'd0;
        end
    end

    assign busy          = (state != IDLE);
    assign byteTransDone = (state == DONE);

endmodule

// File: doc/virtual_ds2431_byte_tx.md
VIRTUAL_DS2431_BYTE_TX -- requirements
Module: virtual_ds2431_byte_tx

Interface
REQ-001 Parameter HOLD_CYC, default 1500, clk cycles the slave holds DQ low when sending a 0 bit (30 us at 50 MHz).
REQ-002 Parameter RST_DET_CYC, default 20000, continuous-low clk cycles on DQ that count as a master bus reset (400 us at 50 MHz); legal range HOLD_CYC < RST_DET_CYC <= 65535.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 dqIn  input  1  raw 1-Wire bus level (asynchronous to clk).
REQ-006 sentDat  input  8  byte to transmit; sampled only on an accepted transTrig.
REQ-007 transTrig  input  1  start request, level-sampled each cycle.
REQ-008 dqPullLow  output  1  1 = drive DQ low (open-drain enable).
REQ-009 byteTransDone  output  1  one-cycle pulse when all 8 bits have been sent.
REQ-010 busy  output  1  high from the cycle after transTrig is accepted until return to IDLE.
REQ-011 busResetDet  output  1  one-cycle pulse when a master reset low is detected mid-byte.

Function
REQ-012 dqIn SHALL pass through a 2-flop synchronizer (dqSync), with a third flop for falling-edge detect (fallEdge = prev 1, now 0).
REQ-013 FSM states SHALL be IDLE, WAIT_SLOT, DRIVE, RECOVER, DONE.
REQ-014 IDLE: transTrig=1 -> latch sentDat into an 8-bit shift register, clear 3-bit bitCnt, go to WAIT_SLOT; fallEdge in IDLE ignored.
REQ-015 transTrig while not in IDLE (including DONE) SHALL be ignored; the shift register is unchanged.
REQ-016 WAIT_SLOT: on fallEdge with shift[0]=0 -> dqPullLow=1 on the next edge, load holdCnt, go to DRIVE; with shift[0]=1 -> go to RECOVER, dqPullLow stays 0.
REQ-017 Slot latency: dqPullLow SHALL rise exactly 4 clk edges after dqIn falls (2 sync + edge flop + registered output).
REQ-018 DRIVE: dqPullLow held high for exactly HOLD_CYC cycles, then deasserted, go to RECOVER.
REQ-019 RECOVER: wait for dqSync=1, then shift right by 1 and increment bitCnt; if bitCnt was 7 go to DONE, else WAIT_SLOT.
REQ-020 Bits SHALL be sent LSB first, one per master read slot.
REQ-021 DONE lasts one cycle: byteTransDone=1, busy=0 on exit, return to IDLE.
REQ-022 A 16-bit lowCnt SHALL count consecutive cycles with dqSync=0 in WAIT_SLOT, DRIVE and RECOVER; it clears whenever dqSync=1.
REQ-023 lowCnt reaching RST_DET_CYC SHALL abort: dqPullLow=0, busResetDet pulses one cycle, go to IDLE, no byteTransDone; abort takes priority over every other transition in the same cycle.
REQ-024 The counter SHALL saturate, never wrap; a low held past abort produces only one busResetDet pulse.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, and set dqPullLow, byteTransDone, busy, busResetDet to 0, shift register, bitCnt, holdCnt, lowCnt to 0, and synchronizer flops to 1 (bus idle).
REQ-026 rst mid-byte (including during DRIVE) SHALL release DQ on that same edge, and no done or reset pulse SHALL be emitted.

Verification (bench parameters HOLD_CYC=8, RST_DET_CYC=64; master slot = 2 cycles low, then released, 40-cycle period)
REQ-027 sentDat=8'h2D with 8 slots -> dqPullLow asserted for 8 cycles in slots 2, 5, 7 and 8 only; byteTransDone pulses once after slot 8 returns high.
REQ-028 sentDat=8'h00 then 8'hFF back-to-back, with transTrig re-raised after the first done -> 8 driven slots, then 0 driven slots, with 2 done pulses.
REQ-029 transTrig pulsed with sentDat=8'hAA during busy after an 8'h2D start -> transmitted pattern remains 8'h2D.
REQ-030 Master holds DQ low 100 cycles after bit 3 -> busResetDet pulses once, 64 cycles after dqSync falls; busy=0, no done; the next transTrig starts cleanly.
REQ-031 rst during DRIVE of bit 1 -> dqPullLow=0 after that edge, all outputs 0, and subsequent DQ edges cause no drive.
REQ-032 DQ falling edges in IDLE -> dqPullLow stays 0, and busy/done stay 0.
